// File: rtl/pc_redirect_ctrl.sv
// Execute-stage PC redirect controller: compares resolved branch/jumps against the fetch prediction,
// issues one redirect over valid/ready, then holds the IF/ID squash window. Optional macro: BJ_PERF_CNT_EN.
module pc_redirect_ctrl #(
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bj_valid,
  input  logic        i_bj_taken,
  input  logic [31:0] i_bj_pc,
  input  logic [31:0] i_bj_target,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  output logic        o_redirect_valid,
  input  logic        i_redirect_ready,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_stall_ex,
  output logic        o_misalign,
  output logic [31:0] o_misalign_pc,
  output logic [31:0] o_bj_count,
  output logic [31:0] o_mispred_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } state_t;

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  state_t      state_q;
  logic [3:0]  squash_cnt_q;
  logic        redirect_valid_q;
  logic        flush_q;
  logic        stall_q;
  logic        misalign_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] misalign_pc_q;

  logic        sample_d;
  logic        misalign_d;
  logic        mispredict_d;
  logic [31:0] correct_pc_d;

  assign sample_d     = i_bj_valid && (state_q == IDLE);
  assign misalign_d   = i_bj_taken && (i_bj_target[1:0] != 2'b00);
  assign mispredict_d = (i_bj_taken != i_pred_taken) ||
                        (i_bj_taken && i_pred_taken && (i_bj_target != i_pred_target));
  assign correct_pc_d = i_bj_taken ? i_bj_target : (i_bj_pc + 32'd4);

  // Redirect/squash sequencing; all handshake and pipeline-control outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q          <= IDLE;
      squash_cnt_q     <= 4'd0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      misalign_q       <= 1'b0;
      redirect_pc_q    <= 32'h0;
      misalign_pc_q    <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_d && misalign_d) begin
            misalign_q    <= 1'b1;
            misalign_pc_q <= i_bj_pc;
          end else if (sample_d && mispredict_d) begin
            redirect_pc_q    <= correct_pc_d;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            stall_q          <= 1'b1;
            state_q          <= REDIRECT;
          end else begin
            state_q <= IDLE;
          end
        end
        REDIRECT: begin
          if (i_redirect_ready) begin
            redirect_valid_q <= 1'b0;
            squash_cnt_q     <= SQ_LOAD;
            state_q          <= SQUASH;
          end else begin
            state_q <= REDIRECT;
          end
        end
        SQUASH: begin
          // Counter reaching 1 marks the final squash cycle.
          if (squash_cnt_q <= 4'd1) begin
            flush_q <= 1'b0;
            stall_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            squash_cnt_q <= squash_cnt_q - 4'd1;
          end
        end
        default: begin
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
          stall_q          <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

`ifdef BJ_PERF_CNT_EN
  logic [31:0] bj_count_q;
  logic [31:0] mispred_count_q;

  // Branch performance counters; wrong-path instructions outside IDLE are never counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bj_count_q      <= 32'h0;
      mispred_count_q <= 32'h0;
    end else begin
      if (sample_d) begin
        bj_count_q <= bj_count_q + 32'd1;
      end else begin
        bj_count_q <= bj_count_q;
      end
      if (sample_d && !misalign_d && mispredict_d) begin
        mispred_count_q <= mispred_count_q + 32'd1;
      end else begin
        mispred_count_q <= mispred_count_q;
      end
    end
  end

  assign o_bj_count      = bj_count_q;
  assign o_mispred_count = mispred_count_q;
`else
  assign o_bj_count      = 32'h0;
  assign o_mispred_count = 32'h0;
`endif

  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_flush          = flush_q;
  assign o_stall_ex       = stall_q;
  assign o_misalign       = misalign_q;
  assign o_misalign_pc    = misalign_pc_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed vector table, reset corner case and
// randomized traffic against a behavioural model of redirect/squash sequencing.
module tb_pc_redirect_ctrl;
  localparam int SQ = 2;

  logic        clk;
  logic        rst_n;
  logic        bj_valid, bj_taken, pred_taken, redirect_ready;
  logic [31:0] bj_pc, bj_target, pred_target;
  logic        redirect_valid, flush, stall_ex, misalign;
  logic [31:0] redirect_pc, misalign_pc, bj_count, mispred_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_redirect_ctrl #(.SQUASH_CYCLES(SQ)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bj_valid(bj_valid), .i_bj_taken(bj_taken), .i_bj_pc(bj_pc), .i_bj_target(bj_target),
    .i_pred_taken(pred_taken), .i_pred_target(pred_target),
    .o_redirect_valid(redirect_valid), .i_redirect_ready(redirect_ready),
    .o_redirect_pc(redirect_pc), .o_flush(flush), .o_stall_ex(stall_ex),
    .o_misalign(misalign), .o_misalign_pc(misalign_pc),
    .o_bj_count(bj_count), .o_mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an outstanding request plus a count of squash cycles still to run.
  bit          m_req;
  int          m_left;
  bit          m_mis;
  logic [31:0] m_rpc, m_mpc, m_bj, m_mp;

  task automatic model_reset();
    m_req = 0; m_left = 0; m_mis = 0;
    m_rpc = 32'h0; m_mpc = 32'h0; m_bj = 32'h0; m_mp = 32'h0;
  endtask

  task automatic model_step();
    m_mis = 0;
    if (m_req) begin
      if (redirect_ready) begin
        m_req  = 0;
        m_left = SQ;
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (bj_valid) begin
      m_bj = m_bj + 32'd1;
      if (bj_taken && (bj_target % 4 != 0)) begin
        m_mis = 1;
        m_mpc = bj_pc;
      end else if ((bj_taken != pred_taken) || (bj_taken && bj_target != pred_target)) begin
        m_req = 1;
        m_rpc = bj_taken ? bj_target : bj_pc + 32'd4;
        m_mp  = m_mp + 32'd1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic busy;
    busy = m_req || (m_left > 0);
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_req});
    chk("flush", {31'd0, flush}, {31'd0, busy});
    chk("stall_ex", {31'd0, stall_ex}, {31'd0, busy});
    chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
    chk("misalign_pc", misalign_pc, m_mpc);
    if (m_req) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BJ_PERF_CNT_EN
    chk("bj_count", bj_count, m_bj);
    chk("mispred_count", mispred_count, m_mp);
`else
    chk("bj_count", bj_count, 32'h0);
    chk("mispred_count", mispred_count, 32'h0);
`endif
  endtask

  // One cycle: inputs already driven on the falling edge, check #1 after the rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic        v, t;
    logic [31:0] pc, tgt;
    logic        pt;
    logic [31:0] ptgt;
    logic        rdy;
    logic        e_rv, e_fl, e_mis;
    logic [31:0] e_rpc, e_mpc;
  } vec_t;

  function automatic vec_t mk(logic v, logic t, logic [31:0] pc, logic [31:0] tgt, logic pt,
                              logic [31:0] ptgt, logic rdy, logic e_rv, logic e_fl, logic e_mis,
                              logic [31:0] e_rpc, logic [31:0] e_mpc);
    vec_t r;
    r.v = v; r.t = t; r.pc = pc; r.tgt = tgt; r.pt = pt; r.ptgt = ptgt; r.rdy = rdy;
    r.e_rv = e_rv; r.e_fl = e_fl; r.e_mis = e_mis; r.e_rpc = e_rpc; r.e_mpc = e_mpc;
    return r;
  endfunction

  task automatic drive(logic v, logic t, logic [31:0] pc, logic [31:0] tgt, logic pt,
                       logic [31:0] ptgt, logic rdy);
    bj_valid = v; bj_taken = t; bj_pc = pc; bj_target = tgt;
    pred_taken = pt; pred_target = ptgt; redirect_ready = rdy;
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(1'b1, 1'b1, 32'h100, 32'h140, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h140, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h140, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h140, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h140, 32'h0);
    tbl[4]  = mk(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    tbl[6]  = mk(1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0);
    tbl[9]  = mk(1'b1, 1'b1, 32'h700, 32'h800, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0);
    tbl[10] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0);
    tbl[11] = mk(1'b1, 1'b1, 32'h300, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0);
    tbl[12] = mk(1'b1, 1'b1, 32'h400, 32'h1002, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h204, 32'h400);
    tbl[13] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'h400);
    tbl[14] = mk(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h400);
    tbl[15] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400);
    tbl[16] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400);
    tbl[17] = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h400);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    chk_model();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].t, tbl[i].pc, tbl[i].tgt, tbl[i].pt, tbl[i].ptgt, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d.valid", i), {31'd0, redirect_valid}, {31'd0, tbl[i].e_rv});
      chk($sformatf("tbl%0d.flush", i), {31'd0, flush}, {31'd0, tbl[i].e_fl});
      chk($sformatf("tbl%0d.misalign", i), {31'd0, misalign}, {31'd0, tbl[i].e_mis});
      chk($sformatf("tbl%0d.misalign_pc", i), misalign_pc, tbl[i].e_mpc);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d.redirect_pc", i), redirect_pc, tbl[i].e_rpc);
    end

    // Asynchronous reset between edges while a redirect is waiting for fetch.
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h900, 32'h980, 1'b0, 32'h0, 1'b0);
    cycle();
    chk("pre_reset.valid", {31'd0, redirect_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.valid", {31'd0, redirect_valid}, 32'd0);
    chk("async_rst.flush", {31'd0, flush}, 32'd0);
    chk("async_rst.stall", {31'd0, stall_ex}, 32'd0);
    chk("async_rst.redirect_pc", redirect_pc, 32'h0);
    chk("async_rst.bj_count", bj_count, 32'h0);
    chk("async_rst.mispred_count", mispred_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, tgt, ptgt;
      @(negedge clk);
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      tgt = $urandom();
      if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
      ptgt = ($urandom_range(0, 1) == 1) ? tgt : ($urandom() & 32'hFFFF_FFFC);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, tgt,
            1'($urandom_range(0, 1)), ptgt, ($urandom_range(0, 9) < 4));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller behind the branch/jump decision datapath in the execute stage. It takes each resolved control-transfer result, checks it against the fetch-stage prediction, and on a mismatch issues one PC redirect to fetch over a valid/ready handshake. Around that handshake it drives the IF/ID squash window and an execute stall. It also flags misaligned targets and, optionally, keeps branch performance counters.

## Interface
Parameters:
- SQUASH_CYCLES, 2, cycles `o_flush` stays high after the redirect handshake (1..15)

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_bj_valid  in  1  execute holds a resolved branch/jump this cycle
- i_bj_taken  in  1  actual outcome (jumps always 1)
- i_bj_pc  in  32  PC of the branch/jump
- i_bj_target  in  32  computed target (pc+imm, or rs1+imm for JALR)
- i_pred_taken  in  1  fetch-stage prediction carried with the instruction
- i_pred_target  in  32  predicted target (ignored when i_pred_taken=0)
- o_redirect_valid  out  1  redirect request to fetch
- i_redirect_ready  in  1  fetch accepts the redirect
- o_redirect_pc  out  32  corrected next PC
- o_flush  out  1  squash IF/ID pipeline registers
- o_stall_ex  out  1  hold execute/issue
- o_misalign  out  1  one-cycle pulse: taken target with bits [1:0] != 0
- o_misalign_pc  out  32  i_bj_pc of the faulting instruction
- o_bj_count  out  32  resolved branch/jumps (perf counter)
- o_mispred_count  out  32  mispredictions (perf counter)

## Operation
- FSM states: IDLE, REDIRECT, SQUASH.
- IDLE: i_bj_valid is sampled on every clock edge. For a sampled instruction:
  - correct = i_bj_taken ? i_bj_target : i_bj_pc + 4 (32-bit add, wraps modulo 2^32).
  - mispredict = (i_bj_taken != i_pred_taken) | (i_bj_taken & i_pred_taken & (i_bj_target != i_pred_target)).
- Misaligned target (i_bj_taken & i_bj_target[1:0] != 0): takes priority over the mispredict path.
  - o_misalign pulses for 1 cycle; o_misalign_pc is latched.
  - No redirect is issued; the FSM stays in IDLE.
- Mispredict, aligned: latch correct into o_redirect_pc and go to REDIRECT.
- Correct prediction: no action.
- REDIRECT:
  - o_redirect_valid=1, o_flush=1, o_stall_ex=1.
  - o_redirect_pc is held stable until the handshake (valid & ready).
  - On handshake: load the squash counter with SQUASH_CYCLES and go to SQUASH.
- SQUASH:
  - o_flush=1, o_stall_ex=1, o_redirect_valid=0.
  - The counter decrements each cycle; when it reaches 1, return to IDLE.
- Outside IDLE, i_bj_valid is ignored: it is wrong-path, and it is not counted.
- Reset (asynchronous, any state): FSM to IDLE. All outputs 0: o_redirect_pc=0, o_misalign_pc=0, counters=0. An in-flight redirect is dropped.

## Timing
- Latency from sampling a mispredict edge to o_redirect_valid/o_flush/o_stall_ex high: 1 cycle (registered outputs).
- Handshake in the same cycle valid rises: REDIRECT lasts 1 cycle.
- Flush duration is SQUASH_CYCLES + (number of REDIRECT cycles).
- After the last SQUASH cycle, i_bj_valid is sampled again in the next IDLE cycle. There is no bubble beyond the FSM itself.
- o_misalign: high exactly 1 cycle, the cycle after sampling.
- i_redirect_ready high while o_redirect_valid=0 has no effect.

## Configuration
- BJ_PERF_CNT_EN defined:
  - o_bj_count increments on every i_bj_valid sampled in IDLE.
  - o_mispred_count increments on every mispredict that enters REDIRECT.
  - Both counters are 32-bit and wrap at 2^32.
  - A misaligned target counts toward o_bj_count only.
- BJ_PERF_CNT_EN undefined: no counter registers are built; both outputs are tied to 32'h0.

## Test plan
- BEQ taken, predicted not-taken (i_bj_pc=0x100, target=0x140, i_redirect_ready=1) -> next cycle: o_redirect_valid=1, o_redirect_pc=0x140, o_flush=1. Flush stays high 1+2 cycles; then IDLE.
- Branch not taken, predicted taken (pc=0x200, pred_target=0x80) -> o_redirect_pc=0x204. With ready held low 3 cycles, valid and o_redirect_pc=0x204 stay stable for 4 cycles, then SQUASH for 2 cycles.
- JAL taken, predicted taken with the same target 0x300 -> no redirect, no flush. With BJ_PERF_CNT_EN: o_bj_count=1, o_mispred_count=0.
- Taken JALR with target 0x1002 (pc=0x400) -> o_misalign 1-cycle pulse, o_misalign_pc=0x400, o_redirect_valid stays 0.
- Second i_bj_valid asserted during REDIRECT/SQUASH -> ignored: no extra redirect, counters unchanged.
- i_rst_n pulled low mid-REDIRECT (asynchronously, between edges) -> o_redirect_valid, o_flush and o_stall_ex drop immediately. After release: state IDLE, counters 0.
